uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Byte buffer that sits directly upstream of uart_tx. It accepts bytes from a producer at full clock rate, stores them in a DEPTH-entry circular FIFO, and drains them one at a time into uart_tx through the tx_start/tx_data/tx_busy handshake. This lets producers burst bytes without tracking serial timing.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO depth; DEPTH = 2**DEPTH_LOG2 entries (default 16)
DATA_WIDTH, 8, byte width; must match uart_tx data width

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
wr_en  input  1  producer write strobe, one byte per cycle
wr_data  input  DATA_WIDTH  byte to enqueue
full  output  1  FIFO holds DEPTH bytes
empty  output  1  FIFO holds 0 bytes
count  output  DEPTH_LOG2+1  current occupancy, 0..DEPTH
overflow  output  1  sticky flag: a write was dropped while full
ovf_clr  input  1  clears overflow
idle  output  1  empty and FSM in IDLE; nothing queued or in flight
tx_start  output  1  start request to uart_tx
tx_data  output  DATA_WIDTH  byte presented to uart_tx
tx_busy  input  1  busy indication from uart_tx

Behaviour:
- Reset (synchronous, active-high, takes priority over everything): rd/wr pointers 0, count 0, full 0, empty 1, overflow 0, tx_start 0, tx_data 0, idle 1, FSM = IDLE. Stored contents are discarded. Reset mid-transfer drops tx_start on the next edge; the byte already in uart_tx is not recalled.
- Write: if wr_en && !full, mem[wr_ptr] <= wr_data and wr_ptr increments modulo DEPTH. If wr_en && full, the byte is dropped, pointers and count do not change, and overflow <= 1.
- full is evaluated on the registered count. A write while full is rejected even if a pop happens in the same cycle.
- overflow: cleared by ovf_clr. If ovf_clr and a dropped write occur in the same cycle, set wins.
- Pop: taken only in IDLE when !empty && !tx_busy. On that edge:
  - tx_data <= mem[rd_ptr]
  - rd_ptr increments modulo DEPTH
  - FSM -> START
- Simultaneous accepted write and pop: count unchanged, both pointers advance.
- No fall-through: a byte written into an empty FIFO is visible to the pop logic on the next cycle.
  - Single-write latency: wr_en sampled at edge N, pop at edge N+1, tx_start high in the cycle after edge N+1.
- Pointer wrap: pointers are DEPTH_LOG2 bits and wrap naturally. count is the authoritative full/empty source.
- FSM states:
  - IDLE: tx_start 0. Pop condition met -> START.
  - START: tx_start 1, tx_data held. Stays here while tx_busy == 0, with no timeout; tx_start is a level request. tx_busy == 1 -> WAIT_DONE, and tx_start deasserts on that edge.
  - WAIT_DONE: tx_start 0, tx_data held. tx_busy == 0 -> IDLE.
- Back-to-back bytes: at least one IDLE cycle separates the falling tx_busy from the next tx_start.
- tx_data changes only on a pop edge. It is stable from START through the return to IDLE.
- idle = empty && FSM == IDLE, registered-equivalent; no combinational path from wr_en.
- Writes are accepted in every FSM state.

Test Plan:
- Single byte: reset, write 0x3D once; loop uart_tx (100 MHz, 115200 baud, parity 1, 2 stop bits) to uart_rx -> tx_start rises 2 cycles after wr_en, and tx_data = 0x3D through tx_busy. rx_valid with rx_data = 0x3D; idle returns to 1 after tx_busy falls.
- Burst: write 0x3D, 0xC3, 0xAA, 0x55 on 4 consecutive cycles -> count peaks at 3 or 4, and uart_rx yields the same four bytes in order. There is exactly one tx_start assertion per byte, separated by at least one IDLE cycle.
- Overflow: hold tx_busy = 1 (uart_tx detached), write 17 bytes 0x00..0x10 -> after the 16th write full = 1, count = 16. The 17th write sets overflow, and count stays 16. Release tx_busy -> bytes 0x00..0x0F are drained in order and 0x10 never appears. ovf_clr clears overflow.
- Simultaneous write/pop: with count = 1 and IDLE, assert wr_en (0xA5) on the pop cycle -> count stays 1 and both bytes are sent in order. Repeat at count = 16 with wr_en -> write is rejected, overflow = 1, count = 15.
- Stalled sink: keep tx_busy = 0 forever after a write -> FSM stays in START with tx_start held 1 and tx_data constant. No further pops occur, and later writes accumulate in count.
- Reset mid-operation: assert reset while in WAIT_DONE with count = 5 -> next cycle count = 0, empty = 1, tx_start = 0, overflow = 0, FSM IDLE. No new tx_start occurs after tx_busy falls.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of uart_tx: buffers producer bytes and hands them to
// the serialiser one at a time over the tx_start/tx_data/tx_busy handshake.
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    input  logic                  ovf_clr,
    output logic                  idle,
    output logic                  tx_start,
    output logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_busy,
    output logic [1:0]            state_dbg
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_DEPTH = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_START     = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    // Handshake: tx_start is a level request held in START until uart_tx
    // answers with tx_busy=1; tx_data is stable from the pop until the next pop.
    state_t                  state, state_next;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr, rd_ptr;
    logic                    wr_acc, pop;

    assign full      = (count == CNT_DEPTH);
    assign empty     = (count == '0);
    assign wr_acc    = wr_en && !full;
    assign pop       = (state == S_IDLE) && !empty && !tx_busy;
    assign idle      = empty && (state == S_IDLE);
    assign state_dbg = state;

    always_comb begin
        state_next = state;
        tx_start   = 1'b0;
        case (state)
            S_IDLE: begin
                if (pop) state_next = S_START;
            end
            S_START: begin
                tx_start = 1'b1;
                if (tx_busy) state_next = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (!tx_busy) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            tx_data  <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop) begin
                rd_ptr  <= rd_ptr + PTR_ONE;
                tx_data <= mem[rd_ptr];
            end
            case ({wr_acc, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            // A dropped write outranks a clear in the same cycle.
            if (wr_en && full) overflow <= 1'b1;
            else if (ovf_clr)  overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a hand-computed vector table, directed corner
// sequences, and random traffic against a queue-based reference model.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       ovf_clr = 1'b0;
    logic       tx_busy = 1'b0;
    logic       full, empty, overflow, idle, tx_start;
    logic [4:0] count;
    logic [7:0] tx_data;
    logic [1:0] state_dbg;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(.DEPTH_LOG2(4), .DATA_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .count(count), .overflow(overflow),
        .ovf_clr(ovf_clr), .idle(idle), .tx_start(tx_start),
        .tx_data(tx_data), .tx_busy(tx_busy), .state_dbg(state_dbg)
    );

    // Reference model: queue of stored bytes, a request phase
    // (0 nothing in flight, 1 requesting, 2 sink busy), held byte, sticky flag.
    logic [7:0] m_q[$];
    int         m_phase = 0;
    logic [7:0] m_data = 8'h00;
    bit         m_ovf = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_q.delete();
            m_phase = 0;
            m_data  = 8'h00;
            m_ovf   = 1'b0;
        end else begin
            bit was_full, do_pop;
            was_full = (m_q.size() == DEPTH);
            do_pop   = (m_phase == 0) && (m_q.size() > 0) && !tx_busy;
            if (do_pop) m_data = m_q.pop_front();
            if (wr_en && !was_full) m_q.push_back(wr_data);
            if (wr_en && was_full) m_ovf = 1'b1;
            else if (ovf_clr)      m_ovf = 1'b0;
            if (do_pop)                         m_phase = 1;
            else if (m_phase == 1 && tx_busy)   m_phase = 2;
            else if (m_phase == 2 && !tx_busy)  m_phase = 0;
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    endtask

    task automatic check_model();
        bit m_empty;
        m_empty = (m_q.size() == 0);
        chk("m_count",    32'(count),    32'(m_q.size()));
        chk("m_full",     32'(full),     32'(m_q.size() == DEPTH));
        chk("m_empty",    32'(empty),    32'(m_empty));
        chk("m_overflow", 32'(overflow), 32'(m_ovf));
        chk("m_idle",     32'(idle),     32'(m_empty && m_phase == 0));
        chk("m_tx_start", 32'(tx_start), 32'(m_phase == 1));
        chk("m_tx_data",  32'(tx_data),  32'(m_data));
    endtask

    // Sink emulation and capture of each new tx_start request.
    bit         sink_auto = 1'b0;
    int         sink_wait = 0;
    int         sink_hold = 0;
    bit         prev_start = 1'b0;
    logic [7:0] got_q[$];

    task automatic cycle();
        @(posedge clk);
        #1;
        check_model();
        if (tx_start && !prev_start) got_q.push_back(tx_data);
        prev_start = tx_start;
        if (sink_auto) begin
            if (tx_busy) begin
                if (sink_hold == 0) tx_busy = 1'b0;
                else sink_hold--;
            end else if (tx_start) begin
                if (sink_wait == 0) begin
                    tx_busy   = 1'b1;
                    sink_hold = $urandom_range(0, 6);
                    sink_wait = $urandom_range(0, 2);
                end else begin
                    sink_wait--;
                end
            end
        end
    endtask

    task automatic drive(bit r, bit we, logic [7:0] d, bit clr);
        reset = r; wr_en = we; wr_data = d; ovf_clr = clr;
        cycle();
        reset = 1'b0; wr_en = 1'b0; ovf_clr = 1'b0;
    endtask

    task automatic wait_idle(int budget);
        int n;
        n = 0;
        while (!(idle && !tx_busy) && n < budget) begin
            drive(1'b0, 1'b0, 8'h00, 1'b0);
            n++;
        end
        chk("drain_timeout", 32'(n < budget), 32'd1);
    endtask

    typedef struct {
        logic       rst, we;
        logic [7:0] wd;
        logic       clr, busy;
        logic [4:0] cnt;
        logic       full, empty, ovf, idle, start;
        logic [7:0] data;
    } vec_t;

    vec_t vecs[14];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // rst we wd clr busy | cnt full empty ovf idle start data
        vecs[0]  = '{1, 0, 8'h00, 0, 0, 5'd0, 0, 1, 0, 1, 0, 8'h00};
        vecs[1]  = '{0, 1, 8'h3D, 0, 0, 5'd1, 0, 0, 0, 0, 0, 8'h00};
        vecs[2]  = '{0, 0, 8'h00, 0, 0, 5'd0, 0, 1, 0, 0, 1, 8'h3D};
        vecs[3]  = '{0, 0, 8'h00, 0, 0, 5'd0, 0, 1, 0, 0, 1, 8'h3D};
        vecs[4]  = '{0, 0, 8'h00, 0, 1, 5'd0, 0, 1, 0, 0, 0, 8'h3D};
        vecs[5]  = '{0, 0, 8'h00, 0, 1, 5'd0, 0, 1, 0, 0, 0, 8'h3D};
        vecs[6]  = '{0, 0, 8'h00, 0, 0, 5'd0, 0, 1, 0, 1, 0, 8'h3D};
        vecs[7]  = '{0, 1, 8'hC3, 0, 0, 5'd1, 0, 0, 0, 0, 0, 8'h3D};
        vecs[8]  = '{0, 1, 8'hAA, 0, 0, 5'd1, 0, 0, 0, 0, 1, 8'hC3};
        vecs[9]  = '{0, 1, 8'h55, 0, 1, 5'd2, 0, 0, 0, 0, 0, 8'hC3};
        vecs[10] = '{0, 0, 8'h00, 0, 0, 5'd2, 0, 0, 0, 0, 0, 8'hC3};
        vecs[11] = '{0, 0, 8'h00, 0, 0, 5'd1, 0, 0, 0, 0, 1, 8'hAA};
        vecs[12] = '{0, 0, 8'h00, 1, 1, 5'd1, 0, 0, 0, 0, 0, 8'hAA};
        vecs[13] = '{1, 0, 8'h00, 0, 0, 5'd0, 0, 1, 0, 1, 0, 8'h00};

        for (int i = 0; i < 14; i++) begin
            tx_busy = vecs[i].busy;
            drive(vecs[i].rst, vecs[i].we, vecs[i].wd, vecs[i].clr);
            chk($sformatf("v%0d_count", i), 32'(count),    32'(vecs[i].cnt));
            chk($sformatf("v%0d_full", i),  32'(full),     32'(vecs[i].full));
            chk($sformatf("v%0d_empty", i), 32'(empty),    32'(vecs[i].empty));
            chk($sformatf("v%0d_ovf", i),   32'(overflow), 32'(vecs[i].ovf));
            chk($sformatf("v%0d_idle", i),  32'(idle),     32'(vecs[i].idle));
            chk($sformatf("v%0d_start", i), 32'(tx_start), 32'(vecs[i].start));
            chk($sformatf("v%0d_data", i),  32'(tx_data),  32'(vecs[i].data));
        end
        chk("reset_state_idle", 32'(state_dbg), 32'd0);

        // Overflow: sink held busy, 17 writes, then drain and clear.
        tx_busy = 1'b1;
        got_q.delete();
        for (int i = 0; i < 17; i++) begin
            drive(1'b0, 1'b1, 8'(i), 1'b0);
            if (i == 15) begin
                chk("ovf_full_at_16", 32'(full), 32'd1);
                chk("ovf_count_at_16", 32'(count), 32'd16);
                chk("ovf_not_yet", 32'(overflow), 32'd0);
            end
        end
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_count_held", 32'(count), 32'd16);
        tx_busy = 1'b0;
        sink_auto = 1'b1;
        wait_idle(2000);
        chk("ovf_drain_len", 32'(got_q.size()), 32'd16);
        for (int i = 0; i < 16 && i < got_q.size(); i++)
            chk($sformatf("ovf_drain_%0d", i), 32'(got_q[i]), 32'(i));
        chk("ovf_still_set", 32'(overflow), 32'd1);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        chk("ovf_cleared", 32'(overflow), 32'd0);

        // Full FIFO: pop and rejected write on the same edge.
        sink_auto = 1'b0;
        tx_busy = 1'b1;
        for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, 8'(8'h80 + i), 1'b0);
        tx_busy = 1'b0;
        drive(1'b0, 1'b1, 8'hEE, 1'b0);
        chk("fullpop_count", 32'(count), 32'd15);
        chk("fullpop_ovf", 32'(overflow), 32'd1);
        chk("fullpop_data", 32'(tx_data), 32'h80);
        drive(1'b1, 1'b0, 8'h00, 1'b0);

        // Stalled sink: request held forever, writes accumulate.
        tx_busy = 1'b0;
        drive(1'b0, 1'b1, 8'h77, 1'b0);
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 8'(8'h10 + i), 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 8'h00, 1'b0);
        chk("stall_start", 32'(tx_start), 32'd1);
        chk("stall_data", 32'(tx_data), 32'h77);
        chk("stall_count", 32'(count), 32'd3);

        // Reset in WAIT_DONE with five bytes queued.
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, 8'(8'h40 + i), 1'b0);
        tx_busy = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        chk("midrst_pre_count", 32'(count), 32'd5);
        chk("midrst_pre_state", 32'(state_dbg), 32'd2);
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_empty", 32'(empty), 32'd1);
        chk("midrst_start", 32'(tx_start), 32'd0);
        chk("midrst_state", 32'(state_dbg), 32'd0);
        tx_busy = 1'b0;
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 8'h00, 1'b0);
        chk("midrst_no_start", 32'(tx_start), 32'd0);

        // Random traffic against the model with an emulated sink.
        got_q.delete();
        prev_start = 1'b0;
        sink_auto = 1'b1;
        for (int i = 0; i < 800; i++)
            drive(1'b0, $urandom_range(0, 99) < 40, 8'($urandom), $urandom_range(0, 49) == 0);
        wait_idle(3000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
